// File: rtl/byte_lane_regfile.sv
// Byte-lane register file with two combinational read ports, optional
// write-to-read forwarding and a per-register pending (busy) scoreboard.
module byte_lane_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   WrEn,
  input  logic [ADDR_W-1:0]      WrAddr,
  input  logic [DATA_W-1:0]      WrData,
  input  logic [DATA_W/8-1:0]    WrByteEn,
  input  logic [ADDR_W-1:0]      RdAddrA,
  output logic [DATA_W-1:0]      RdDataA,
  input  logic [ADDR_W-1:0]      RdAddrB,
  output logic [DATA_W-1:0]      RdDataB,
  input  logic                   BusySetEn,
  input  logic [ADDR_W-1:0]      BusySetAddr,
  output logic                   BusyA,
  output logic                   BusyB
);

  localparam int unsigned NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [DATA_W-1:0] wr_mask;
  logic              wr_ok;
  logic              set_ok;
  logic              byp_a;
  logic              byp_b;
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;

  // Expand byte enables into a bit mask used by both the write and the forward merge
  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      wr_mask[i*8 +: 8] = {8{WrByteEn[i]}};
    end
  end

  assign wr_ok  = WrEn && !(ZERO_REG && (WrAddr == '0));
  assign set_ok = BusySetEn && !(ZERO_REG && (BusySetAddr == '0));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs[r] <= '0;
      end
    end else if (wr_ok) begin
      regs[WrAddr] <= (regs[WrAddr] & ~wr_mask) | (WrData & wr_mask);
    end
  end

  // Set is written after clear so a newly issued producer wins on the same register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      if (WrEn) begin
        busy[WrAddr] <= 1'b0;
      end
      if (set_ok) begin
        busy[BusySetAddr] <= 1'b1;
      end
    end
  end

  // Forwarding is suppressed while in reset so reads show the cleared state
  assign byp_a    = BYPASS && !Reset && WrEn && (WrAddr == RdAddrA);
  assign byp_b    = BYPASS && !Reset && WrEn && (WrAddr == RdAddrB);
  assign stored_a = regs[RdAddrA];
  assign stored_b = regs[RdAddrB];

  always_comb begin
    RdDataA = stored_a;
    RdDataB = stored_b;
    if (byp_a) begin
      RdDataA = (stored_a & ~wr_mask) | (WrData & wr_mask);
    end
    if (byp_b) begin
      RdDataB = (stored_b & ~wr_mask) | (WrData & wr_mask);
    end
    if (ZERO_REG && (RdAddrA == '0)) begin
      RdDataA = '0;
    end
    if (ZERO_REG && (RdAddrB == '0)) begin
      RdDataB = '0;
    end
  end

  assign BusyA = busy[RdAddrA] && !byp_a;
  assign BusyB = busy[RdAddrB] && !byp_b;

endmodule

// File: tb/tb_byte_lane_regfile.sv
// Bench for byte_lane_regfile: a forwarding and a non-forwarding instance share
// stimulus and are checked against an array/byte-level reference every cycle.
module tb_byte_lane_regfile;

  logic        Clk;
  logic        Reset;
  logic        WrEn;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;
  logic [3:0]  WrByteEn;
  logic [4:0]  RdAddrA;
  logic [4:0]  RdAddrB;
  logic        BusySetEn;
  logic [4:0]  BusySetAddr;

  logic [31:0] rda1, rdb1, rda0, rdb0;
  logic        ba1, bb1, ba0, bb0;

  int checks;
  int errors;
  bit run;

  logic [31:0] mdl_mem  [32];
  bit          mdl_busy [32];

  byte_lane_regfile #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_byp (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdDataA(rda1), .RdAddrB(RdAddrB),
    .RdDataB(rdb1), .BusySetEn(BusySetEn), .BusySetAddr(BusySetAddr),
    .BusyA(ba1), .BusyB(bb1)
  );

  byte_lane_regfile #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nobyp (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .WrByteEn(WrByteEn), .RdAddrA(RdAddrA), .RdDataA(rda0), .RdAddrB(RdAddrB),
    .RdDataB(rdb0), .BusySetEn(BusySetEn), .BusySetAddr(BusySetAddr),
    .BusyA(ba0), .BusyB(bb0)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: whole-register array plus one pending flag per register
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int r = 0; r < 32; r++) begin
        mdl_mem[r]  = 32'h0;
        mdl_busy[r] = 1'b0;
      end
    end else begin
      if (WrEn && WrAddr != 5'd0) begin
        for (int b = 0; b < 4; b++) begin
          if (WrByteEn[b]) mdl_mem[WrAddr][b*8 +: 8] = WrData[b*8 +: 8];
        end
      end
      if (WrEn) mdl_busy[WrAddr] = 1'b0;
      if (BusySetEn && BusySetAddr != 5'd0) mdl_busy[BusySetAddr] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit fwd);
    logic [31:0] v;
    if (addr == 5'd0) return 32'h0;
    v = mdl_mem[addr];
    if (fwd && WrEn && WrAddr == addr) begin
      for (int b = 0; b < 4; b++) begin
        if (WrByteEn[b]) v[b*8 +: 8] = WrData[b*8 +: 8];
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] addr, input bit fwd);
    if (fwd && WrEn && WrAddr == addr) return 32'h0;
    return {31'h0, mdl_busy[addr]};
  endfunction

  // Every-cycle comparison of both instances against the reference
  always @(negedge Clk) begin
    if (run && !Reset) begin
      check("byp_rda",    rda1,          exp_rd(RdAddrA, 1'b1));
      check("byp_rdb",    rdb1,          exp_rd(RdAddrB, 1'b1));
      check("byp_busya",  {31'h0, ba1},  exp_busy(RdAddrA, 1'b1));
      check("byp_busyb",  {31'h0, bb1},  exp_busy(RdAddrB, 1'b1));
      check("nbyp_rda",   rda0,          exp_rd(RdAddrA, 1'b0));
      check("nbyp_rdb",   rdb0,          exp_rd(RdAddrB, 1'b0));
      check("nbyp_busya", {31'h0, ba0},  exp_busy(RdAddrA, 1'b0));
      check("nbyp_busyb", {31'h0, bb0},  exp_busy(RdAddrB, 1'b0));
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic se, input logic [4:0] sa,
                       input logic [4:0] ra, input logic [4:0] rb);
    WrEn = we; WrAddr = wa; WrData = wd; WrByteEn = be;
    BusySetEn = se; BusySetAddr = sa; RdAddrA = ra; RdAddrB = rb;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    run    = 1'b0;
    Reset  = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    run   = 1'b1;

    // Reset state
    @(negedge Clk);
    check("reset_rda", rda1, 32'h0);
    check("reset_busyb", {31'h0, bb1}, 32'h0);
    next_cycle();

    // Reset mid-write: committed r5 and a pending r5 write are both discarded
    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b1, 5'd5, 5'd5, 5'd5);
    next_cycle();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd5, 5'd5);
    @(negedge Clk);
    check("pre_reset_r5", rda0, 32'hDEADBEEF);
    #2;
    Reset = 1'b1;
    #1;
    check("midreset_rda_byp",  rda1, 32'h0);
    check("midreset_rda_nbyp", rda0, 32'h0);
    check("midreset_busya",    {31'h0, ba0}, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    Reset = 1'b0;
    @(negedge Clk);
    check("postreset_r5", rda0, 32'h0);
    next_cycle();

    // Byte lanes
    drive(1'b1, 5'd3, 32'h11223344, 4'hF, 1'b0, 5'd0, 5'd3, 5'd0);
    next_cycle();
    drive(1'b1, 5'd3, 32'hAABBCCDD, 4'h5, 1'b0, 5'd0, 5'd3, 5'd0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    @(negedge Clk);
    check("bytelane_byp",  rda1, 32'h11BB33DD);
    check("bytelane_nbyp", rdb0, 32'h11BB33DD);
    next_cycle();

    // Zero register
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd3, 5'd0);
    @(negedge Clk);
    check("zero_rdb_during", rdb1, 32'h0);
    check("zero_busyb_during", {31'h0, bb0}, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge Clk);
    check("zero_rdb_after", rdb0, 32'h0);
    check("zero_busyb_after", {31'h0, bb0}, 32'h0);
    next_cycle();

    // Forwarding merge vs. one-cycle latency
    drive(1'b1, 5'd7, 32'h12345678, 4'hC, 1'b0, 5'd0, 5'd7, 5'd0);
    @(negedge Clk);
    check("bypass_merge",   rda1, 32'h12340000);
    check("nobypass_stale", rda0, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    @(negedge Clk);
    check("nobypass_after", rda0, 32'h12340000);
    next_cycle();

    // Scoreboard ordering on r9
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd9, 5'd9, 5'd9);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("sb_idle_busy", {31'h0, ba1}, 32'h1);
      next_cycle();
    end
    drive(1'b1, 5'd9, 32'h0000_0099, 4'hF, 1'b1, 5'd9, 5'd9, 5'd9);
    @(negedge Clk);
    check("sb_setclr_byp_during",  {31'h0, ba1}, 32'h0);
    check("sb_setclr_nbyp_during", {31'h0, ba0}, 32'h1);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    @(negedge Clk);
    check("sb_set_wins", {31'h0, ba1}, 32'h1);
    next_cycle();
    drive(1'b1, 5'd9, 32'h0000_0042, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    @(negedge Clk);
    check("sb_clr_byp_during",  {31'h0, ba1}, 32'h0);
    check("sb_clr_nbyp_during", {31'h0, ba0}, 32'h1);
    check("sb_empty_be_data",   rda1, 32'h0000_0099);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd9, 5'd9);
    @(negedge Clk);
    check("sb_clr_after", {31'h0, ba0}, 32'h0);
    next_cycle();

    // Dual-port independence
    drive(1'b1, 5'd12, 32'hCAFEF00D, 4'hF, 1'b1, 5'd4, 5'd12, 5'd12);
    @(negedge Clk);
    check("dual_rda", rda1, 32'hCAFEF00D);
    check("dual_rdb", rdb1, 32'hCAFEF00D);
    check("dual_busya", {31'h0, ba1}, 32'h0);
    check("dual_busyb", {31'h0, bb1}, 32'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd4, 5'd12);
    @(negedge Clk);
    check("dual_r4_busy", {31'h0, ba0}, 32'h1);
    check("dual_r12_data", rdb0, 32'hCAFEF00D);
    next_cycle();

    // Randomized traffic over a narrow address window to force collisions
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 11)), $urandom,
            4'($urandom), 1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 11)),
            5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
      if (n == 300) begin
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("rand_reset_rda", rda1, 32'h0);
        check("rand_reset_busyb", {31'h0, bb1}, 32'h0);
        next_cycle();
        Reset = 1'b0;
      end else begin
        next_cycle();
      end
    end

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_lane_regfile.md
Name: byte_lane_regfile

Overview:
Parametrised register file with byte-lane write enables, two asynchronous read ports, optional write-to-read bypass and a per-register busy scoreboard. It is the successor to the single 32-bit byte-enabled write register and sits in the ID stage of the 5-stage pipeline. Writes come from WB; the scoreboard is set at issue and cleared at writeback, so hazard logic can stall on pending producers.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8; NBYTES = DATA_W/8
NREGS, 32, number of registers; must be a power of 2
ADDR_W, 5, address width; must equal log2(NREGS)
BYPASS, 1, 1 = same-cycle write data is forwarded to reads and to busy outputs; 0 = reads see stored state only
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
WrEn  in  1  write strobe from WB
WrAddr  in  ADDR_W  write register index
WrData  in  DATA_W  write data
WrByteEn  in  NBYTES  per-byte write enable; bit i covers bits [8i+7:8i]
RdAddrA  in  ADDR_W  read port A index
RdDataA  out  DATA_W  read port A data, combinational
RdAddrB  in  ADDR_W  read port B index
RdDataB  out  DATA_W  read port B data, combinational
BusySetEn  in  1  issue-time strobe marking a register as pending
BusySetAddr  in  ADDR_W  register to mark pending
BusyA  out  1  pending flag for RdAddrA
BusyB  out  1  pending flag for RdAddrB

Behaviour:
- Reset asserted (async): all NREGS registers clear to 0 and all busy bits clear to 0. RdData* then read 0 and Busy* read 0. Reset applied mid-write discards that write. Reset deassertion has no special sequencing.
- Write: on a rising Clk edge with WrEn=1, each byte i with WrByteEn[i]=1 takes WrData byte i. All other bytes hold their value.
- WrEn=1 with WrByteEn all 0 writes no data but still clears busy.
- With ZERO_REG=1, a write to address 0 is dropped entirely.
- Read (combinational): RdDataX = reg[RdAddrX]. With ZERO_REG=1 and address 0, RdDataX = 0.
- Bypass (BYPASS=1, WrEn=1, WrAddr==RdAddrX, and the address is not zero under ZERO_REG): RdDataX is a per-byte merge. Enabled bytes come from WrData; the rest come from the stored value. This gives zero-cycle forwarding.
- Bypass with BYPASS=0: the new value is visible on RdDataX in the cycle after the edge (1-cycle latency).
- Ports A and B are fully independent and may address the same register.
- Scoreboard: on a rising edge:
  - BusySetEn=1 sets busy[BusySetAddr].
  - WrEn=1 clears busy[WrAddr].
  - Same address set and cleared in one edge: set wins (a new producer has been issued).
  - Different addresses: both actions take effect.
  - Setting a register that is already busy leaves it busy; there is no counting.
  - With ZERO_REG=1, busy[0] is never set.
- BusyX = busy[RdAddrX], except when BYPASS=1 and WrEn=1 and WrAddr==RdAddrX in the current cycle; then BusyX = 0, because the data is available through the bypass.
- Width rules: there are no arithmetic operations. Addresses are used as-is; NREGS is a power of 2, so no out-of-range handling is needed.

Test Plan:
- Reset mid-write: write 0xDEADBEEF to r5 with WrByteEn=1111, then assert Reset between clock edges -> RdDataA(r5)=0 immediately and BusyA=0; after release, r5 still reads 0.
- Byte lanes: load r3=0x11223344, then write 0xAABBCCDD with WrByteEn=0101 -> r3 reads 0x11BB33DD on the next cycle.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and set busy on r0 -> RdDataB(r0)=0 and BusyB=0.
- Bypass merge (BYPASS=1): with r7=0x00000000, drive WrEn with WrData=0x12345678, WrByteEn=1100, RdAddrA=7 in the same cycle -> RdDataA=0x12340000 before the edge. Repeat with BYPASS=0 -> 0x00000000 before the edge and 0x12340000 after it.
- Scoreboard ordering: BusySetEn on r9, then 3 idle cycles -> BusyA(r9)=1 throughout. Then WrEn to r9 with BusySetEn on r9 in the same edge -> r9 stays busy. Then WrEn alone -> BusyA(r9)=0 after the edge, and 0 during the write cycle when BYPASS=1.
- Dual-port independence: RdAddrA=RdAddrB=12 while writing r12 and setting busy on r4 in the same edge -> both ports return identical data, BusyA=BusyB, and r4 is busy on the next cycle.
